// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants for the board I/O front end: MMIO addresses of the switch
// read port, the switch count and the default debounce timing.
// No ports (package).
// -----------------------------------------------------------------------------
package io_pkg;

    // Number of slide switches on the board.
    localparam int SW_WIDTH = 16;

    // Default debounce timing (1 ms sample period at 100 MHz).
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TICK_CYCLES = 100_000;
    localparam int DEF_SAMPLES     = 4;

    // MMIO addresses served by the switch read port.
    localparam logic [31:0] CONFIRM_ADDR  = 32'hFFFF_FF00;
    localparam logic [31:0] SW_ADDR_FIRST = 32'hFFFF_FFF1;
    localparam logic [31:0] SW_ADDR_LAST  = 32'hFFFF_FFF9;

    // A load from the confirmation address through the switch port.
    function automatic logic is_confirm_read(input logic        ctrl,
                                             input logic [31:0] addr,
                                             input logic [31:0] match);
        return ctrl && (addr == match);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One synchronise-and-debounce lane. The raw bit passes through a plain
// SYNC_STAGES flip-flop chain; on every shared sample tick the synchronised
// bit is shifted into a SAMPLES-deep history, and the stable level follows
// only when the whole history agrees.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous reset, active-high
//   tick    in  one-cycle sample strobe shared by all lanes
//   raw     in  asynchronous input bit
//   stable  out debounced level (registered, changes only on tick cycles)
// -----------------------------------------------------------------------------
module debounce_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLES     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SAMPLES-1:0]     hist_q;
    logic [SAMPLES-1:0]     hist_d;
    logic                   stable_q;

    // History as it will be after this tick; the level decision uses the
    // new sample so the output moves on the same tick that completes a run.
    assign hist_d = {hist_q[SAMPLES-2:0], sync_q[SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            hist_q   <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (tick) begin
                hist_q <= hist_d;
                if (&hist_d) begin
                    stable_q <= 1'b1;
                end else if (~|hist_d) begin
                    stable_q <= 1'b0;
                end
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Front end for the slide switches and the confirm button. All raw inputs are
// synchronised and debounced on a shared sample tick; each debounced press of
// the button sets a sticky confirmation flag that is cleared when the CPU
// reads CONFIRM_ADDR through the switch port.
// Ports:
//   clk           in  system clock
//   rst           in  synchronous reset, active-high
//   switchRaw     in  [SW_WIDTH] asynchronous switch pads
//   buttonRaw     in  asynchronous confirm button, 1 = pressed
//   switchCtrl    in  switch-port read strobe
//   address       in  [32] CPU load address qualifying switchCtrl
//   switchInput   out [SW_WIDTH] debounced switch levels
//   buttonLevel   out debounced button level
//   confirmation  out sticky "pressed and not yet read" flag
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int          SW_WIDTH     = io_pkg::SW_WIDTH,
    parameter int          SYNC_STAGES  = io_pkg::DEF_SYNC_STAGES,
    parameter int          TICK_CYCLES  = io_pkg::DEF_TICK_CYCLES,
    parameter int          SAMPLES      = io_pkg::DEF_SAMPLES,
    parameter logic [31:0] CONFIRM_ADDR = io_pkg::CONFIRM_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] switchRaw,
    input  logic                buttonRaw,
    input  logic                switchCtrl,
    input  logic [31:0]         address,
    output logic [SW_WIDTH-1:0] switchInput,
    output logic                buttonLevel,
    output logic                confirmation
);

    import io_pkg::*;

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    // ---------------- sample tick ----------------
    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    assign tick = (cnt_q == CNT_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // ---------------- debounce lanes ----------------
    // Lane SW_WIDTH is the button; the rest are the switches.
    logic [SW_WIDTH:0] raw_all;
    logic [SW_WIDTH:0] stable_all;

    assign raw_all = {buttonRaw, switchRaw};

    for (genvar g = 0; g <= SW_WIDTH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .SAMPLES     (SAMPLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .raw    (raw_all[g]),
            .stable (stable_all[g])
        );
    end

    assign switchInput = stable_all[SW_WIDTH-1:0];
    assign buttonLevel = stable_all[SW_WIDTH];

    // ---------------- press edge + sticky flag ----------------
    logic btn_prev_q;
    logic press_evt;
    logic clear_rd;
    logic confirm_q;
    logic confirm_d;

    assign press_evt = buttonLevel & ~btn_prev_q;
    assign clear_rd  = is_confirm_read(switchCtrl, address, CONFIRM_ADDR);

    // Set beats clear so a press landing on the reading cycle survives for
    // the next read.
    always_comb begin
        confirm_d = confirm_q;
        if (press_evt) begin
            confirm_d = 1'b1;
        end else if (clear_rd) begin
            confirm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
            confirm_q  <= 1'b0;
        end else begin
            btn_prev_q <= buttonLevel;
            confirm_q  <= confirm_d;
        end
    end

    assign confirmation = confirm_q;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Directed bench for input_conditioner with TICK_CYCLES=4, SAMPLES=3,
// SYNC_STAGES=2. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int          SW_W  = 16;
    localparam logic [31:0] A_CFM = 32'hFFFF_FF00;
    localparam logic [31:0] A_SW1 = 32'hFFFF_FFF1;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic [SW_W-1:0] switchRaw;
    logic            buttonRaw;
    logic            switchCtrl;
    logic [31:0]     address;
    logic [SW_W-1:0] switchInput;
    logic            buttonLevel;
    logic            confirmation;

    always #5 clk = ~clk;

    // Rising edges since reset release; stable outputs may only move on
    // edges where this count is a multiple of TICK_CYCLES.
    int ecnt = 0;
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    input_conditioner #(
        .SW_WIDTH     (SW_W),
        .SYNC_STAGES  (2),
        .TICK_CYCLES  (4),
        .SAMPLES      (3),
        .CONFIRM_ADDR (A_CFM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .switchRaw    (switchRaw),
        .buttonRaw    (buttonRaw),
        .switchCtrl   (switchCtrl),
        .address      (address),
        .switchInput  (switchInput),
        .buttonLevel  (buttonLevel),
        .confirmation (confirmation)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_at(input logic [31:0] a);
        switchCtrl = 1'b1;
        address    = a;
        cyc(1);
        switchCtrl = 1'b0;
        address    = 32'h0;
    endtask

    // ---------------- directed sequence ----------------
    int   n;
    logic seen;
    logic bad;
    int   gap;

    initial begin
        rst        = 1'b1;
        switchRaw  = 16'hFFFF;
        buttonRaw  = 1'b1;
        switchCtrl = 1'b0;
        address    = 32'h0;

        // 1: reset holds everything low, including the first free cycle
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("rst_sw",   32'(switchInput),  32'h0);
            chk("rst_btn",  32'(buttonLevel),  32'h0);
            chk("rst_conf", 32'(confirmation), 32'h0);
        end
        rst = 1'b0;
        cyc(1);
        chk("post_rst_sw",   32'(switchInput),  32'h0);
        chk("post_rst_btn",  32'(buttonLevel),  32'h0);
        chk("post_rst_conf", 32'(confirmation), 32'h0);
        switchRaw = 16'h0;
        buttonRaw = 1'b0;
        cyc(20);
        chk("idle_sw", 32'(switchInput), 32'h0);

        // 2: clean change appears within 11..15 cycles, on a tick edge
        switchRaw = 16'hA5C3;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            cyc(1);
            n++;
            if (switchInput !== 16'h0) seen = 1'b1;
        end
        chk("sw_value",   32'(switchInput),                32'hA5C3);
        chk("sw_latency", 32'(n >= 11 && n <= 15),         32'h1);
        chk("sw_on_tick", 32'((ecnt % 4) == 0),            32'h1);

        // 3: 3-cycle glitches on bit 0 at random phases never get through
        switchRaw = 16'hA5C2;
        cyc(20);
        chk("glitch_base", 32'(switchInput), 32'hA5C2);
        for (int g = 0; g < 6; g++) begin
            bad = 1'b0;
            gap = $urandom_range(12, 5);
            for (int i = 0; i < gap; i++) begin
                cyc(1);
                bad = bad | switchInput[0];
            end
            switchRaw[0] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cyc(1);
                bad = bad | switchInput[0];
            end
            switchRaw[0] = 1'b0;
            chk("glitch_reject", 32'(bad), 32'h0);
        end
        cyc(16);
        chk("glitch_after", 32'(switchInput), 32'hA5C2);

        // 4: press sets the flag, confirm read clears it, other reads do not
        buttonRaw = 1'b1;
        cyc(20);
        chk("press_btn",  32'(buttonLevel),  32'h1);
        chk("press_conf", 32'(confirmation), 32'h1);
        read_at(A_CFM);
        chk("read_clear", 32'(confirmation), 32'h0);
        buttonRaw = 1'b0;
        cyc(20);
        chk("release_btn", 32'(buttonLevel), 32'h0);
        buttonRaw = 1'b1;
        cyc(20);
        chk("press2_conf", 32'(confirmation), 32'h1);
        read_at(A_SW1);
        chk("other_addr_hold", 32'(confirmation), 32'h1);
        address = A_CFM;
        cyc(1);
        address = 32'h0;
        chk("no_strobe_hold", 32'(confirmation), 32'h1);
        read_at(A_CFM);
        chk("read_clear2", 32'(confirmation), 32'h0);

        // 5a: clear-read on the same cycle as the press event -> set wins
        buttonRaw = 1'b0;
        cyc(20);
        buttonRaw = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            cyc(1);
            n++;
            if (buttonLevel === 1'b1) seen = 1'b1;
        end
        chk("evt_seen",        32'(seen),         32'h1);
        chk("conf_before_evt", 32'(confirmation), 32'h0);
        read_at(A_CFM);
        chk("set_wins", 32'(confirmation), 32'h1);
        cyc(1);
        chk("set_wins_hold", 32'(confirmation), 32'h1);
        read_at(A_CFM);
        chk("read_clear3", 32'(confirmation), 32'h0);

        // 5b: two presses collapse into one flag, one read clears it
        buttonRaw = 1'b0;
        cyc(20);
        buttonRaw = 1'b1;
        cyc(20);
        buttonRaw = 1'b0;
        cyc(20);
        buttonRaw = 1'b1;
        cyc(20);
        chk("two_press_conf", 32'(confirmation), 32'h1);
        read_at(A_CFM);
        chk("two_press_clear", 32'(confirmation), 32'h0);
        cyc(10);
        chk("hold_no_rearm", 32'(confirmation), 32'h0);

        // 6: reset mid-debounce discards history; full latency again after
        buttonRaw = 1'b0;
        cyc(20);
        buttonRaw = 1'b1;
        cyc(6);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_conf", 32'(confirmation), 32'h0);
        chk("mid_rst_btn",  32'(buttonLevel),  32'h0);
        chk("mid_rst_sw",   32'(switchInput),  32'h0);
        rst  = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            cyc(1);
            n++;
            if (confirmation === 1'b1) seen = 1'b1;
        end
        chk("mid_rst_rise",    32'(seen),                32'h1);
        chk("mid_rst_latency", 32'(n >= 11 && n <= 16), 32'h1);
        cyc(20);
        chk("mid_rst_sw_back", 32'(switchInput), 32'hA5C2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
